ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Parametrised multiplexed seven-segment display driver and the successor to the fixed 4-digit scanner. It drives any number of common-anode digits with its own scan prescaler. Display updates are double-buffered so a frame never shows a mix of old and new values. It also provides per-digit decimal points, optional leading-zero blanking and an optional brightness PWM. It sits between any register/memory readout path and the board's anode/cathode pins.

## Interface

- NUM_DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 262144, clock cycles each digit stays selected; must be a multiple of 16 and ≥16
- Clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- data_in  in  4*NUM_DIGITS  hex nibbles; digit k = data_in[4k+3:4k], digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit
- data_valid  in  1  one-cycle strobe; captures data_in and dp_in
- blank_lz  in  1  1 = blank leading zero digits
- brightness  in  4  duty level, 15 = full; present only with SSD_BRIGHTNESS_EN
- an  out  NUM_DIGITS  anodes, active low
- seg  out  7  cathodes {a,b,c,d,e,f,g}, active low
- dp  out  1  decimal-point cathode, active low
- frame_start  out  1  one-cycle pulse when digit 0 becomes selected

## Operation

- Prescaler `pc` counts 0..SCAN_DIV-1 and wraps. When `pc == SCAN_DIV-1`, digit index `idx` advances; it wraps from NUM_DIGITS-1 to 0.
- Buffers:
  - `pending` register with flag `pflag`. On `data_valid`, data_in/dp_in are written to `pending` and `pflag` is set.
  - The frame boundary is `pc == SCAN_DIV-1` and `idx == NUM_DIGITS-1`. At the boundary, if `pflag` is set, `pending` copies to `active` and `pflag` clears.
  - If `data_valid` coincides with the boundary, data_in/dp_in go straight to `active` and `pflag` clears (newest wins).
  - Back-to-back `data_valid` strobes overwrite `pending`; the last one wins.
- Leading-zero blanking (blank_lz=1), computed on `active`:
  - Starting from digit NUM_DIGITS-1 and moving downward, a digit is blanked while its nibble is 0 and its dp bit is 0.
  - The first nonzero nibble or set dp bit ends the run.
  - Digit 0 is never blanked.
  - A blanked digit drives seg=7'b1111111 and dp=1, but its anode still scans.
- Font is a standard hex table, active low. Examples: 0→0000001, 1→1001111, 8→0000000, A→0001000, F→0111000.
- Output encoding: an = ~(1<<idx) gated by PWM; dp = ~active_dp[idx]; seg = font(active nibble[idx]) unless blanked.
- frame_start is high for exactly one cycle, in the cycle where the registered an first selects digit 0.

## Timing

- All outputs are registered and reflect `idx`/`active` of the previous cycle (1-cycle latency).
- Reset values:
  - an all ones; seg 7'b1111111; dp 1; frame_start 0.
  - pc 0; idx 0; pending, active and pflag all 0.
- First edge after reset deasserts: an[0]=0, showing "0" on digit 0 (blank_lz=1 shows only digit 0). frame_start is high in that same cycle.
- Latency from `data_valid` to display: at most NUM_DIGITS*SCAN_DIV+1 cycles; the update takes effect at the next frame boundary.
- Reset asserted mid-frame returns everything to reset values on that edge and drops any pending update.

## Configuration

- SSD_BRIGHTNESS_EN defined:
  - The `brightness` port exists.
  - Within each slot, the anode is active only while `pc[3:0] <= brightness`.
  - brightness=0 gives 1/16 duty; brightness=15 gives full duty.
  - seg/dp are unaffected by the PWM.
- SSD_BRIGHTNESS_EN undefined: the port is absent and anodes run at full duty.

## Structure

- Package `ssd_pkg`:
  - font constants for the 16 hex glyphs
  - SEG_BLANK = 7'b1111111
  - a localparam helper for the idx width, $clog2(NUM_DIGITS) with a minimum of 1
- Sub-module `ssd_hex_font`: 4-bit nibble in, 7-bit active-low pattern out, purely combinational. It is instantiated once on the selected nibble.

## Test plan

Benches use SCAN_DIV=16 and NUM_DIGITS=4.

- Reset, then release with no strobe → `an` sequence 1110,1101,1011,0111, each held 16 cycles. seg=0000001 throughout. frame_start pulses every 64 cycles.
- Strobe data_in=16'h12AF mid-frame → display unchanged until the frame boundary. The next frame shows digit0 F=0111000, digit1 A=0001000, digit2 2=0010010, digit3 1=1001111.
- blank_lz=1, data_in=16'h0030, dp_in=4'b0000 → digits 3 and 2 show seg=1111111. Digit1 shows 3=0000110, digit0 shows 0=0000001.
- blank_lz=1, data_in=16'h0005, dp_in=4'b0100 → digit3 blank. Digit2 shows 0 with dp=0 (lit). Digit1 shows 0; digit0 shows 5.
- Two strobes (16'h1111, then 16'h2222) within one frame, with a third strobe (16'h3333) exactly on the boundary cycle → next frame shows 3333. pflag is clear afterwards.
- With SSD_BRIGHTNESS_EN, brightness=3 → each anode is low for pc[3:0]=0..3 only (4 of 16 cycles). Assert reset mid-slot → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyphs
// (active low, {a,b,c,d,e,f,g}), the blank pattern and a width helper.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] FONT_0 = 7'b0000001;
  localparam logic [6:0] FONT_1 = 7'b1001111;
  localparam logic [6:0] FONT_2 = 7'b0010010;
  localparam logic [6:0] FONT_3 = 7'b0000110;
  localparam logic [6:0] FONT_4 = 7'b1001100;
  localparam logic [6:0] FONT_5 = 7'b0100100;
  localparam logic [6:0] FONT_6 = 7'b0100000;
  localparam logic [6:0] FONT_7 = 7'b0001111;
  localparam logic [6:0] FONT_8 = 7'b0000000;
  localparam logic [6:0] FONT_9 = 7'b0000100;
  localparam logic [6:0] FONT_A = 7'b0001000;
  localparam logic [6:0] FONT_B = 7'b1100000;
  localparam logic [6:0] FONT_C = 7'b0110001;
  localparam logic [6:0] FONT_D = 7'b1000010;
  localparam logic [6:0] FONT_E = 7'b0110000;
  localparam logic [6:0] FONT_F = 7'b0111000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd_hex_font.sv
// Combinational hex-to-segment decoder, active-low outputs.
// Instantiated once on the currently selected nibble.
module ssd_hex_font
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = FONT_0;
      4'h1: seg = FONT_1;
      4'h2: seg = FONT_2;
      4'h3: seg = FONT_3;
      4'h4: seg = FONT_4;
      4'h5: seg = FONT_5;
      4'h6: seg = FONT_6;
      4'h7: seg = FONT_7;
      4'h8: seg = FONT_8;
      4'h9: seg = FONT_9;
      4'ha: seg = FONT_A;
      4'hb: seg = FONT_B;
      4'hc: seg = FONT_C;
      4'hd: seg = FONT_D;
      4'he: seg = FONT_E;
      4'hf: seg = FONT_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode 7-seg scanner with double-buffered frames.
// Define SSD_BRIGHTNESS_EN to add the 4-bit brightness PWM input.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 262144
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    data_valid,
  input  logic                    blank_lz,
`ifdef SSD_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic                    pflag;
  logic                    pc_last;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    run;
  logic [3:0]              nib;
  logic [6:0]              font_seg;
  logic                    pwm_on;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    sel0;

  assign pc_last  = (pc == PC_LAST);
  assign boundary = pc_last && (idx == IDX_LAST);

  always_ff @(posedge Clk) begin
    if (reset) begin
      pc  <= '0;
      idx <= '0;
    end else begin
      pc <= pc_last ? '0 : pc + 1'b1;
      if (pc_last)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // A strobe on the boundary bypasses pending so the newest data wins.
  always_ff @(posedge Clk) begin
    if (reset) begin
      pend_data <= '0;
      pend_dp   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      pflag     <= 1'b0;
    end else begin
      if (data_valid) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end
      if (boundary && data_valid) begin
        act_data <= data_in;
        act_dp   <= dp_in;
        pflag    <= 1'b0;
      end else if (boundary && pflag) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        pflag    <= 1'b0;
      end else if (data_valid) begin
        pflag <= 1'b1;
      end
    end
  end

  always_comb begin
    blank = '0;
    run   = blank_lz;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (run && act_data[4*k +: 4] == 4'h0 && !act_dp[k])
        blank[k] = 1'b1;
      else
        run = 1'b0;
    end
  end

  assign nib = act_data[{idx, 2'b00} +: 4];

  ssd_hex_font u_font (
    .nib (nib),
    .seg (font_seg)
  );

`ifdef SSD_BRIGHTNESS_EN
  assign pwm_on = (pc[3:0] <= brightness);
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    an_n      = '1;
    an_n[idx] = ~pwm_on;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
      sel0        <= 1'b0;
    end else begin
      an          <= an_n;
      seg         <= blank[idx] ? SEG_BLANK : font_seg;
      dp          <= blank[idx] | ~act_dp[idx];
      sel0        <= (idx == '0);
      frame_start <= (idx == '0) && !sel0;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver (NUM_DIGITS=4, SCAN_DIV=16).
module tb_ssd_scan_driver;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int FR = ND * SD;

  localparam logic [6:0] FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
`ifdef SSD_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'hf;
`endif
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  ssd_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .data_valid  (data_valid),
    .blank_lz    (blank_lz),
`ifdef SSD_BRIGHTNESS_EN
    .brightness  (brightness),
`endif
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  initial begin : model
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    bit          m_pf, run, bnd, pwm;
    bit [3:0]    blk;
    int          d;
    exp_t        e;
    m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pf = 0;
    forever begin
      @(posedge Clk);
      if (reset) begin
        e = '{an: 4'hf, seg: 7'h7f, dp: 1'b1, fs: 1'b0};
        exp_q.push_back(e);
        cyc = 0;
        m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pf = 0;
      end else begin
        d = (cyc / SD) % ND;
        blk = '0;
        run = blank_lz;
        for (int k = ND - 1; k >= 1; k--) begin
          if (run && ((m_act >> (4 * k)) & 16'hf) == 0 && !m_adp[k])
            blk[k] = 1'b1;
          else
            run = 0;
        end
`ifdef SSD_BRIGHTNESS_EN
        pwm = (cyc % 16) <= int'(brightness);
`else
        pwm = 1;
`endif
        e.an = 4'hf;
        if (pwm) e.an[d] = 1'b0;
        e.seg = blk[d] ? 7'h7f : FONT[(m_act >> (4 * d)) & 16'hf];
        e.dp  = blk[d] ? 1'b1 : !m_adp[d];
        e.fs  = (cyc % FR) == 0;
        exp_q.push_back(e);
        bnd = (cyc % FR) == FR - 1;
        if (data_valid && bnd) begin
          m_act = data_in; m_adp = dp_in; m_pf = 0;
        end else if (bnd && m_pf) begin
          m_act = m_pend; m_adp = m_pdp; m_pf = 0;
        end else if (data_valid) begin
          m_pend = data_in; m_pdp = dp_in; m_pf = 1;
        end
        cyc++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({an, seg, dp, frame_start} !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
                   $time, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk_reset();
    if (an !== 4'hf || seg !== 7'h7f || dp !== 1'b1 ||
        frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset state t=%0t an=%b seg=%b dp=%b fs=%b",
               $time, an, seg, dp, frame_start);
    end
  endtask

  task automatic strobe(input logic [15:0] d, input logic [3:0] p);
    @(negedge Clk);
    data_in = d;
    dp_in = p;
    data_valid = 1'b1;
    @(negedge Clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    @(negedge Clk);
    while ((cyc % FR) != ph && n < 2 * FR) begin
      @(negedge Clk);
      n++;
    end
    if ((cyc % FR) != ph) begin
      miscompares++;
      $display("FAIL wait_phase(%0d) expired t=%0t", ph, $time);
    end
  endtask

  initial begin : stim
    reset = 1'b1;
    idle(3);
    chk_reset();
    reset = 1'b0;
    idle(2 * FR + 2);

    idle(20);
    strobe(16'h12af, 4'b0000);
    idle(2 * FR + 10);

    blank_lz = 1'b1;
    strobe(16'h0030, 4'b0000);
    idle(2 * FR + 10);

    strobe(16'h0005, 4'b0100);
    idle(2 * FR + 10);

    blank_lz = 1'b0;
    wait_phase(10);
    strobe(16'h1111, 4'b0000);
    idle(5);
    strobe(16'h2222, 4'b0000);
    wait_phase(FR - 1);
    data_in = 16'h3333;
    dp_in = 4'b0000;
    data_valid = 1'b1;
    @(negedge Clk);
    data_valid = 1'b0;
    idle(2 * FR + 10);

`ifdef SSD_BRIGHTNESS_EN
    brightness = 4'd3;
    idle(2 * FR);
`endif

    for (int i = 0; i < 24; i++) begin
      blank_lz = 1'($urandom);
`ifdef SSD_BRIGHTNESS_EN
      brightness = 4'($urandom);
`endif
      strobe(16'($urandom) & ((i % 3 == 0) ? 16'h00ff : 16'hffff),
             4'($urandom) & ((i % 2 == 0) ? 4'b0011 : 4'b1111));
      if (i % 5 == 0)
        strobe(16'($urandom), 4'($urandom));
      idle($urandom_range(1, 150));
    end

    wait_phase(SD + 7);
    strobe(16'h9876, 4'b1010);
    reset = 1'b1;
    @(negedge Clk);
    chk_reset();
    reset = 1'b0;
    idle(2 * FR + 10);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
